remote_cmd_arbiter: RTL and testbench
=====================================

// Module: remote_cmd_arbiter
// PURPOSE
//  Shares the single UART remote-command link (16-bit cmd out as 2 bytes, 8-bit resp in) among NUM_REQ requesters.
//  Round-robin arbitrates, issues one command at a time and waits for the 8-bit response.
//  Retries on NACK or timeout, then reports per-requester completion and status.
//  Sits between the host-side command sources and the remote-comm block.
// PARAMETERS
//  NUM_REQ         2          number of requesters (>=2)
//  TIMEOUT_CYCLES  1_000_000  clk cycles from send_cmd pulse to resp_rdy before declaring timeout
//  MAX_RETRY       2          re-sends after first attempt before giving up
//  POS_ACK         8'hA5      response value meaning success
// PORTS
//  clk           in   1           system clock
//  rst_n         in   1           asynchronous active-low reset
//  req           in   NUM_REQ     level request, held until matching done pulse
//  req_cmd       in   16*NUM_REQ  command of requester i at [16*i+:16]
//  done          out  NUM_REQ     one-cycle pulse to the granted requester at transaction end
//  ok            out  1           valid with done: 1 = POS_ACK received, 0 = NACK/timeout exhausted
//  timed_out     out  1           valid with done: 1 = final attempt ended by timeout
//  last_resp     out  8           valid with done: last response byte (8'h00 if none)
//  busy          out  1           high from grant through done
//  send_cmd      out  1           one-cycle pulse to remote-comm
//  cmd           out  16          command to remote-comm, stable from send_cmd through done
//  cmd_sent      in   1           remote-comm: both bytes transmitted (level)
//  resp_rdy      in   1           remote-comm: response byte valid (level)
//  resp          in   8           remote-comm response byte
//  clr_resp_rdy  out  1           one-cycle pulse clearing resp_rdy
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; cmd=16'h0; rr pointer = NUM_REQ-1 (req[0] wins first).
//  FSM:
//   IDLE: on any req bit, grant the first set bit after the pointer (wrapping).
//     Latch req_cmd slice into cmd, load pointer=grant, retry_cnt=0, go SEND.
//   SEND: pulse send_cmd and clr_resp_rdy. Clear timer. Go WAIT_SENT.
//   WAIT_SENT: wait for cmd_sent, then go WAIT_RESP. resp_rdy here is accepted as in WAIT_RESP.
//   WAIT_RESP: timer increments every cycle in WAIT_SENT/WAIT_RESP. On resp_rdy:
//     pulse clr_resp_rdy and capture resp.
//     If resp==POS_ACK, go DONE with ok=1.
//     Otherwise, if retry_cnt<MAX_RETRY, increment retry_cnt and go SEND; else go DONE with ok=0.
//   Timer==TIMEOUT_CYCLES-1 with no resp_rdy: timeout.
//     Retry as above; on exhaustion, go DONE with ok=0, timed_out=1.
//   DONE: pulse done[grant] for one cycle with ok/timed_out/last_resp registered. Go IDLE.
//  Latency: req->send_cmd = 2 clk (IDLE, SEND). resp_rdy->done = 2 clk (capture, DONE).
//  A new grant cannot occur before the cycle after DONE.
//  busy: 1 from SEND entry through the DONE cycle, 0 in IDLE.
//  Boundaries:
//   - resp_rdy and timeout in the same cycle: response wins.
//   - req deasserted mid-transaction: the transaction still completes and done still pulses; no abort.
//   - req_cmd changes after grant: ignored; the latched cmd is used for all retries.
//   - Stale resp_rdy from a prior transaction: cleared by the SEND clr pulse, so it is never accepted.
//   - Requester re-requests right after its done: rr pointer gives other pending requesters priority.
//   - Reset mid-transaction: immediate return to IDLE, outputs to reset values, no done pulse.
//  Widths:
//   - timer is $clog2(TIMEOUT_CYCLES+1) bits, saturating only via the state exit.
//   - retry_cnt is $clog2(MAX_RETRY+1) bits.
// STRUCTURE
//  remote_cmd_pkg: state_t enum {IDLE,SEND,WAIT_SENT,WAIT_RESP,DONE}, localparam POS_ACK_DEF=8'hA5.
//  Sub-module rr_arbiter #(NUM_REQ): req, ptr -> one-hot grant + index; combinational.
//  Timer, retry counter, FSM and output regs live in the top.
// TESTING
//  1. req=2'b01, cmd=16'h1234, resp=A5 after cmd_sent -> one send_cmd with cmd=1234, done=01, ok=1, last_resp=A5.
//  2. req=2'b11 held, both acked -> grants 0,1,0,1 alternating; never two sends overlapping.
//  3. resp=5A twice, then A5 (MAX_RETRY=2) -> 3 send_cmd pulses, same cmd; done with ok=1.
//  4. no resp_rdy, TIMEOUT_CYCLES=100 -> 3 sends ~100 clk apart; done with ok=0, timed_out=1, last_resp=00.
//  5. resp_rdy on the exact timeout cycle -> accepted as response, no retry; ok=1 if A5.
//  6. rst_n low during WAIT_RESP -> busy=0, send_cmd=0, no done; next req is granted to req[0] first.

Source files
------------

// File: rtl/remote_cmd_pkg.sv
// Shared types and constants for the remote-command arbiter.
//   state_t      : arbiter FSM states
//   POS_ACK_DEF  : default response byte meaning success
package remote_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    DONE
  } state_t;

  localparam logic [7:0] POS_ACK_DEF = 8'hA5;

endpackage

// File: rtl/remote_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       in   NUM_REQ  request vector
//   ptr       in   IW       index of the most recently granted requester
//   grant     out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx out  IW       index of the granted requester
//   any       out  1        at least one request present
// The search starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any
);

  always_comb begin
    int         pos;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = IW'(pos);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/remote_cmd_arbiter.sv
// Shares one remote-command link among NUM_REQ requesters. Round-robin grant,
// one command in flight, retry on NACK or timeout, per-requester done pulse.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req           level request per requester, held until its done pulse
//   req_cmd       16-bit command of requester i at [16*i +: 16]
//   done          one-cycle pulse to the granted requester at transaction end
//   ok            with done: POS_ACK received
//   timed_out     with done: final attempt ended by timeout
//   last_resp     with done: last response byte (00 if none arrived)
//   busy          high from SEND through DONE
//   send_cmd      one-cycle pulse to the link, cmd valid
//   cmd           latched command, stable for the whole transaction
//   cmd_sent      link: both command bytes transmitted (level)
//   resp_rdy      link: response byte valid (level)
//   resp          link: response byte
//   clr_resp_rdy  one-cycle pulse clearing resp_rdy in the link
// All outputs are registered and become visible in the state that owns them:
// send_cmd/clr_resp_rdy during SEND, done/ok/timed_out/last_resp during DONE.
// Because done is seen during DONE, a requester drops req before IDLE samples it.
module remote_cmd_arbiter
  import remote_cmd_pkg::*;
#(
  parameter int         NUM_REQ        = 2,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         MAX_RETRY      = 2,
  parameter logic [7:0] POS_ACK        = POS_ACK_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]     done,
  output logic                   ok,
  output logic                   timed_out,
  output logic [7:0]             last_resp,
  output logic                   busy,
  output logic                   send_cmd,
  output logic [15:0]            cmd,
  input  logic                   cmd_sent,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   clr_resp_rdy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [NUM_REQ-1:0]  grant_reg;
  logic [TW-1:0]       timer;
  logic [RW-1:0]       retry_cnt;
  logic [7:0]          resp_reg;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // An attempt ends on a response or on the last timer cycle; when both
  // happen together the response wins (tmo is masked by resp_rdy).
  logic waiting, rx, tmo, is_ack, can_retry;
  assign waiting   = (state == WAIT_SENT) || (state == WAIT_RESP);
  assign rx        = waiting && resp_rdy;
  assign tmo       = waiting && !resp_rdy && (timer == TIMER_LAST);
  assign is_ack    = (resp == POS_ACK);
  assign can_retry = (retry_cnt < RETRY_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= IW'(NUM_REQ - 1);
      grant_reg    <= '0;
      timer        <= '0;
      retry_cnt    <= '0;
      resp_reg     <= '0;
      done         <= '0;
      ok           <= 1'b0;
      timed_out    <= 1'b0;
      last_resp    <= '0;
      busy         <= 1'b0;
      send_cmd     <= 1'b0;
      cmd          <= '0;
      clr_resp_rdy <= 1'b0;
    end else begin
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      done         <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_reg    <= arb_grant;
            ptr          <= arb_idx;
            cmd          <= req_cmd[16*arb_idx +: 16];
            retry_cnt    <= '0;
            resp_reg     <= '0;
            send_cmd     <= 1'b1;
            clr_resp_rdy <= 1'b1;
            busy         <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          timer <= '0;
          state <= WAIT_SENT;
        end
        WAIT_SENT, WAIT_RESP: begin
          timer <= timer + TW'(1);
          if (state == WAIT_SENT && cmd_sent) state <= WAIT_RESP;
          if (rx) begin
            clr_resp_rdy <= 1'b1;
            resp_reg     <= resp;
          end
          if (rx && is_ack) begin
            done      <= grant_reg;
            ok        <= 1'b1;
            timed_out <= 1'b0;
            last_resp <= resp;
            state     <= DONE;
          end else if (rx || tmo) begin
            if (can_retry) begin
              // Re-send the latched cmd; the SEND clr pulse flushes any stale resp_rdy.
              retry_cnt    <= retry_cnt + RW'(1);
              send_cmd     <= 1'b1;
              clr_resp_rdy <= 1'b1;
              state        <= SEND;
            end else begin
              done      <= grant_reg;
              ok        <= 1'b0;
              timed_out <= tmo;
              last_resp <= rx ? resp : resp_reg;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// Scoreboard bench for remote_cmd_arbiter: stimulus pushes expected send/done
// events (with hand-computed cycle gaps) into a queue; a monitor pops and
// compares whenever the DUT pulses send_cmd or done. A link model answers
// each send according to a per-send script.
module tb_remote_cmd_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TMO     = 100;
  localparam int MAXR    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_cmd = '0;
  logic [NUM_REQ-1:0]    done;
  logic                  ok, timed_out, busy, send_cmd, clr_resp_rdy;
  logic [7:0]            last_resp;
  logic [15:0]           cmd;
  logic                  cmd_sent = 1'b0;
  logic                  resp_rdy = 1'b0;
  logic [7:0]            resp = 8'h00;

  always #5 clk = ~clk;

  // A requester holds req while it has issued more transactions than completed.
  int issued[NUM_REQ];
  int completed[NUM_REQ];
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req[gi] = (issued[gi] != completed[gi]);
    end
  endgenerate

  remote_cmd_arbiter #(
    .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR), .POS_ACK(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .done(done),
    .ok(ok), .timed_out(timed_out), .last_resp(last_resp), .busy(busy),
    .send_cmd(send_cmd), .cmd(cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy),
    .resp(resp), .clr_resp_rdy(clr_resp_rdy)
  );

  typedef struct {
    bit          is_done;
    logic [15:0] cmd;
    logic [1:0]  dv;
    logic        okv;
    logic        tov;
    logic [7:0]  lr;
    int          gap;   // cycles since previous event, 0 = not checked
  } ev_t;

  typedef struct {
    int         sent_at;  // cycles after send_cmd when cmd_sent rises
    int         resp_at;  // cycles after send_cmd when resp_rdy rises, <0 = never
    logic [7:0] val;
  } scr_t;

  ev_t  exp_q[$];
  scr_t scr_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic exp_send(input logic [15:0] c, input int gap);
    ev_t e;
    e = '{is_done: 1'b0, cmd: c, dv: 2'b00, okv: 1'b0, tov: 1'b0, lr: 8'h00, gap: gap};
    exp_q.push_back(e);
  endtask

  task automatic exp_done(input logic [1:0] dv, input logic okv, input logic tov,
                          input logic [7:0] lr, input int gap);
    ev_t e;
    e = '{is_done: 1'b1, cmd: 16'h0, dv: dv, okv: okv, tov: tov, lr: lr, gap: gap};
    exp_q.push_back(e);
  endtask

  task automatic script(input int s, input int r, input logic [7:0] v);
    scr_t x;
    x = '{sent_at: s, resp_at: r, val: v};
    scr_q.push_back(x);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (send_cmd) begin
          $display("cycle %0d send cmd=%h busy=%b", cyc, cmd, busy);
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            total++; bad++;
            $display("FAIL unexpected_send: got send cmd=%h, required none", cmd);
          end else begin
            e = exp_q.pop_front();
            chk("send_cmd_value", cmd, e.cmd);
            chk("busy_on_send", busy, 1);
            if (e.gap != 0) chk("send_gap", cyc - last_cyc, e.gap);
          end
          last_cyc = cyc;
        end
        if (done != '0) begin
          $display("cycle %0d done=%b ok=%b timed_out=%b last_resp=%h", cyc, done, ok, timed_out, last_resp);
          if (exp_q.size() == 0 || !exp_q[0].is_done) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done=%b, required none", done);
          end else begin
            e = exp_q.pop_front();
            chk("done_vec", done, e.dv);
            chk("ok", ok, e.okv);
            chk("timed_out", timed_out, e.tov);
            chk("last_resp", last_resp, e.lr);
            chk("busy_on_done", busy, 1);
            if (e.gap != 0) chk("done_gap", cyc - last_cyc, e.gap);
          end
          last_cyc = cyc;
          for (int i = 0; i < NUM_REQ; i++) if (done[i]) completed[i]++;
        end
      end
    end
  endtask

  task automatic responder();
    scr_t cur;
    bit   active = 1'b0;
    int   cnt = 0;
    cur = '{sent_at: 2, resp_at: 4, val: 8'hA5};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_sent = 1'b0; resp_rdy = 1'b0; resp = 8'h00; active = 1'b0;
      end else begin
        if (clr_resp_rdy) resp_rdy = 1'b0;
        if (send_cmd) begin
          cmd_sent = 1'b0; cnt = 0; active = 1'b1;
          if (scr_q.size() != 0) cur = scr_q.pop_front();
          else cur = '{sent_at: 2, resp_at: 4, val: 8'hA5};
        end else if (active) begin
          cnt++;
          if (cnt == cur.sent_at) cmd_sent = 1'b1;
          if (cnt == cur.resp_at) begin
            resp_rdy = 1'b1; resp = cur.val; active = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s_drain: got %0d events pending, required 0 within 3000 cycles", name, exp_q.size());
      exp_q.delete();
      scr_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic stimulus();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_send_cmd", send_cmd, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_clr", clr_resp_rdy, 0);
    chk("rst_ok", ok, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_last_resp", last_resp, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // 1: single ack
    req_cmd[15:0] = 16'h1234;
    script(2, 4, 8'hA5);
    exp_send(16'h1234, 0);
    exp_done(2'b01, 1'b1, 1'b0, 8'hA5, 5);
    issued[0]++;
    drain("single_ack");

    // 2: both held; pointer is at 0 after test 1, so requester 1 goes first
    req_cmd = {16'hBBBB, 16'hAAAA};
    for (int i = 0; i < 4; i++) script(2, 4, 8'hA5);
    exp_send(16'hBBBB, 0); exp_done(2'b10, 1'b1, 1'b0, 8'hA5, 5);
    exp_send(16'hAAAA, 2); exp_done(2'b01, 1'b1, 1'b0, 8'hA5, 5);
    exp_send(16'hBBBB, 2); exp_done(2'b10, 1'b1, 1'b0, 8'hA5, 5);
    exp_send(16'hAAAA, 2); exp_done(2'b01, 1'b1, 1'b0, 8'hA5, 5);
    issued[0] += 2;
    issued[1] += 2;
    drain("round_robin");

    // 3: NACK, NACK, ACK; req_cmd changed after grant must not leak in
    req_cmd[15:0] = 16'h5555;
    script(2, 4, 8'h5A); script(2, 4, 8'h5A); script(2, 4, 8'hA5);
    exp_send(16'h5555, 0); exp_send(16'h5555, 5); exp_send(16'h5555, 5);
    exp_done(2'b01, 1'b1, 1'b0, 8'hA5, 5);
    issued[0]++;
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    req_cmd[15:0] = 16'hFFFF;
    drain("retry_ack");

    // 3b: three NACKs exhaust the retries
    req_cmd[15:0] = 16'h6666;
    for (int i = 0; i < 3; i++) script(2, 4, 8'h5A);
    exp_send(16'h6666, 0); exp_send(16'h6666, 5); exp_send(16'h6666, 5);
    exp_done(2'b01, 1'b0, 1'b0, 8'h5A, 5);
    issued[0]++;
    drain("nack_exhaust");

    // 4: no response at all on requester 1
    req_cmd[31:16] = 16'h7777;
    for (int i = 0; i < 3; i++) script(2, -1, 8'h00);
    exp_send(16'h7777, 0); exp_send(16'h7777, 101); exp_send(16'h7777, 101);
    exp_done(2'b10, 1'b0, 1'b1, 8'h00, 101);
    issued[1]++;
    drain("timeout");

    // 4b: NACK then two timeouts; last_resp keeps the NACK byte
    req_cmd[15:0] = 16'h8888;
    script(2, 4, 8'h5A); script(2, -1, 8'h00); script(2, -1, 8'h00);
    exp_send(16'h8888, 0); exp_send(16'h8888, 5); exp_send(16'h8888, 101);
    exp_done(2'b01, 1'b0, 1'b1, 8'h5A, 101);
    issued[0]++;
    drain("nack_then_timeout");

    // 5: response lands on the exact timeout cycle
    req_cmd[31:16] = 16'h9999;
    script(2, 100, 8'hA5);
    exp_send(16'h9999, 0);
    exp_done(2'b10, 1'b1, 1'b0, 8'hA5, 101);
    issued[1]++;
    drain("resp_at_timeout");

    // 6: reset while waiting for the response to requester 0
    req_cmd[15:0] = 16'hCCCC;
    script(2, -1, 8'h00);
    exp_send(16'hCCCC, 0);
    issued[0]++;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("mid_reset_send_seen", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    issued[0] = completed[0];
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_send_cmd", send_cmd, 0);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_cmd", cmd, 0);
    chk("mid_reset_clr", clr_resp_rdy, 0);
    repeat (3) @(negedge clk);
    chk("mid_reset_done_held", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    req_cmd = {16'hDDDD, 16'hCCCC};
    script(2, 4, 8'hA5); script(2, 4, 8'hA5);
    exp_send(16'hCCCC, 0); exp_done(2'b01, 1'b1, 1'b0, 8'hA5, 5);
    exp_send(16'hDDDD, 2); exp_done(2'b10, 1'b1, 1'b0, 8'hA5, 5);
    issued[0]++;
    issued[1]++;
    drain("after_reset");
  endtask

  initial begin
    fork
      monitor();
      responder();
    join_none
    stimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
